bit_serializer: RTL

Parallel-to-serial front end that sits directly upstream of the serial sequence detector and drives its one-bit `x` input. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock. Back-to-back words produce a gap-free bit stream, so patterns that straddle a word boundary are still presented to the detector. When no word is in flight, the serial output holds a fixed idle level.

---
 rtl/bit_serializer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the serial sequence detector.
// Accepts WIDTH-bit words over valid/ready and shifts them out one bit per clock.
// Back-to-back words form a gap-free stream so detector patterns may straddle
// a word boundary; with nothing in flight the serial line rests at IDLE_BIT.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             x_last,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);
    localparam logic [WIDTH-1:0] IDLE_WORD  = {WIDTH{IDLE_BIT}};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic             x_q;
    logic             x_valid_q;
    logic             x_last_q;
    logic             accept;

    // The bit that goes on the line first for a given word in transmit order.
    function automatic logic headBit(input logic [WIDTH-1:0] word);
        return MSB_FIRST ? word[WIDTH-1] : word[0];
    endfunction

    // Ready while idle or while the last bit of the current word is on the line.
    // Held low throughout reset so nothing is ever taken while rst is asserted.
    assign din_ready = rst && ((state_q == IDLE) || (cnt_q == CNT_LAST));
    assign accept    = din_valid && din_ready;

    // Shift register advanced by one position, vacated end filled with the idle level.
    always_comb begin
        sreg_d = sreg_q;
        if (MSB_FIRST) begin
            sreg_d = {sreg_q[WIDTH-2:0], IDLE_BIT};
        end else begin
            sreg_d = {IDLE_BIT, sreg_q[WIDTH-1:1]};
        end
    end

    // Control FSM: loads, shifts, reloads back-to-back and returns to idle, with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sreg_q    <= IDLE_WORD;
            x_q       <= IDLE_BIT;
            x_valid_q <= 1'b0;
            x_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= SHIFT;
                        cnt_q     <= '0;
                        sreg_q    <= din;
                        x_q       <= headBit(din);
                        x_valid_q <= 1'b1;
                        x_last_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_q     <= cnt_q + CNT_W'(1);
                        sreg_q    <= sreg_d;
                        x_q       <= headBit(sreg_d);
                        x_valid_q <= 1'b1;
                        x_last_q  <= (cnt_q == CNT_PENULT);
                    end else if (accept) begin
                        cnt_q     <= '0;
                        sreg_q    <= din;
                        x_q       <= headBit(din);
                        x_valid_q <= 1'b1;
                        x_last_q  <= 1'b0;
                    end else begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        sreg_q    <= IDLE_WORD;
                        x_q       <= IDLE_BIT;
                        x_valid_q <= 1'b0;
                        x_last_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    sreg_q    <= IDLE_WORD;
                    x_q       <= IDLE_BIT;
                    x_valid_q <= 1'b0;
                    x_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign x_last  = x_last_q;
    assign busy    = x_valid_q;

endmodule
